// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole front end: FSM states, seven-segment
// glyphs, LFSR taps and the tick rate.
package mole_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StDone} mole_state_e;

    // Active-low gfedcba glyphs
    localparam logic [6:0] Seg0     = 7'b1000000;
    localparam logic [6:0] Seg1     = 7'b1111001;
    localparam logic [6:0] Seg2     = 7'b0100100;
    localparam logic [6:0] Seg3     = 7'b0110000;
    localparam logic [6:0] Seg4     = 7'b0011001;
    localparam logic [6:0] Seg5     = 7'b0010010;
    localparam logic [6:0] Seg6     = 7'b0000010;
    localparam logic [6:0] Seg7     = 7'b1111000;
    localparam logic [6:0] Seg8     = 7'b0000000;
    localparam logic [6:0] Seg9     = 7'b0010000;
    localparam logic [6:0] SegBlank = 7'b1111111;

    // x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LfsrTaps = 8'hB8;

    localparam int unsigned TicksPerSec = 10;

    // Pattern 00 is reserved for gaps, so it folds onto mole 0.
    function automatic logic [1:0] lfsr_to_seq(input logic [1:0] bits);
        return (bits == 2'b00) ? 2'b01 : bits;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD digit to active-low gfedcba segments; anything above 9 blanks the digit.
module seg7_decode
    import mole_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SegBlank;
        case (bcd_i)
            4'd0:    seg_o = Seg0;
            4'd1:    seg_o = Seg1;
            4'd2:    seg_o = Seg2;
            4'd3:    seg_o = Seg3;
            4'd4:    seg_o = Seg4;
            4'd5:    seg_o = Seg5;
            4'd6:    seg_o = Seg6;
            4'd7:    seg_o = Seg7;
            4'd8:    seg_o = Seg8;
            4'd9:    seg_o = Seg9;
            default: seg_o = SegBlank;
        endcase
    end

endmodule

// File: rtl/mole_sequencer.sv
// Round sequencer: free-running LFSR picks mole patterns per slot, 100 ms ticks drive the
// slot/gap timing and the seconds countdown shown on two seven-segment digits.
module mole_sequencer
    import mole_pkg::*;
#(
    parameter int unsigned CLK_HZ       = 50_000_000,
    parameter int unsigned DWELL_TICKS  = 8,
    parameter int unsigned GAP_TICKS    = 2,
    parameter int unsigned GAME_SECONDS = 60,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
    input  logic       clk_i,
    input  logic       clr,
    input  logic       start_i,
    output logic [1:0] seq_o,
    output logic       stop_o,
    output logic [6:0] time_left_o,
    output logic [6:0] disp_s_t_o,
    output logic [6:0] disp_g_t_o
);

    localparam int unsigned PrescMax = CLK_HZ / TicksPerSec - 1;
    localparam int unsigned PrescW   = (PrescMax > 0) ? $clog2(PrescMax + 1) : 1;
    localparam int unsigned SlotW    = $clog2(DWELL_TICKS);

    mole_state_e       state_q;
    logic [7:0]        lfsr_q, lfsr_d;
    logic              start_q;
    logic [PrescW-1:0] presc_q;
    logic [SlotW-1:0]  slot_q;
    logic [3:0]        tenths_q;
    logic [6:0]        time_left_q;
    logic [1:0]        seq_q;
    logic              stop_q;
    logic              start_rise;
    logic              tick;
    logic [3:0]        tens, units;

    assign lfsr_d     = {lfsr_q[6:0], ^(lfsr_q & LfsrTaps)};
    assign start_rise = start_i & ~start_q;
    assign tick       = (state_q == StRun) && (presc_q == PrescW'(PrescMax));

    always_ff @(posedge clk_i or negedge clr) begin
        if (!clr) begin
            state_q     <= StIdle;
            lfsr_q      <= LFSR_SEED;
            start_q     <= 1'b0;
            presc_q     <= '0;
            slot_q      <= '0;
            tenths_q    <= '0;
            time_left_q <= 7'(GAME_SECONDS);
            seq_q       <= 2'b00;
            stop_q      <= 1'b1;
        end else begin
            lfsr_q  <= lfsr_d;
            start_q <= start_i;
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_rise) begin
                        state_q     <= StRun;
                        stop_q      <= 1'b0;
                        seq_q       <= lfsr_to_seq(lfsr_q[1:0]);
                        time_left_q <= 7'(GAME_SECONDS);
                        presc_q     <= '0;
                        slot_q      <= '0;
                        tenths_q    <= '0;
                    end
                end
                StRun: begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (slot_q == SlotW'(DWELL_TICKS - 1)) begin
                            slot_q <= '0;
                            seq_q  <= lfsr_to_seq(lfsr_q[1:0]);
                        end else begin
                            slot_q <= slot_q + 1'b1;
                            if (slot_q == SlotW'(DWELL_TICKS - GAP_TICKS - 1)) begin
                                seq_q <= 2'b00;
                            end
                        end
                        // Placed after the slot logic so end-of-round wins over a slot reload.
                        if (tenths_q == 4'(TicksPerSec - 1)) begin
                            tenths_q <= '0;
                            if (time_left_q == 7'd1) begin
                                state_q     <= StDone;
                                time_left_q <= 7'd0;
                                seq_q       <= 2'b00;
                                stop_q      <= 1'b1;
                            end else begin
                                time_left_q <= time_left_q - 7'd1;
                            end
                        end else begin
                            tenths_q <= tenths_q + 4'd1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tens  = 4'(time_left_q / 7'd10);
    assign units = 4'(time_left_q % 7'd10);

    seg7_decode u_seg_tens (
        .bcd_i (tens),
        .seg_o (disp_s_t_o)
    );

    seg7_decode u_seg_units (
        .bcd_i (units),
        .seg_o (disp_g_t_o)
    );

    assign seq_o       = seq_q;
    assign stop_o      = stop_q;
    assign time_left_o = time_left_q;

endmodule

// File: tb/tb_mole_sequencer.sv
// Directed bench for mole_sequencer with a 10-clock tick, 4-tick slots and a 3 s round;
// mole patterns are predicted by an independent reference LFSR.
module tb_mole_sequencer;

    localparam int SlotClks  = 40;
    localparam int GapStart  = 30;
    localparam int SecClks   = 100;
    localparam int RoundClks = 300;

    logic       clk_i = 1'b0;
    logic       clr   = 1'b0;
    logic       start = 1'b0;
    logic [1:0] seq_o;
    logic       stop_o;
    logic [6:0] time_left_o;
    logic [6:0] disp_s_t_o;
    logic [6:0] disp_g_t_o;

    int  n_checks = 0;
    int  n_bad    = 0;
    bit  seen11   = 1'b0;
    logic [7:0] m_lfsr;

    mole_sequencer #(
        .CLK_HZ       (100),
        .DWELL_TICKS  (4),
        .GAP_TICKS    (1),
        .GAME_SECONDS (3),
        .LFSR_SEED    (8'hA5)
    ) dut (
        .clk_i       (clk_i),
        .clr         (clr),
        .start_i     (start),
        .seq_o       (seq_o),
        .stop_o      (stop_o),
        .time_left_o (time_left_o),
        .disp_s_t_o  (disp_s_t_o),
        .disp_g_t_o  (disp_g_t_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0
    always @(posedge clk_i or negedge clr) begin
        if (!clr) m_lfsr <= 8'hA5;
        else      m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [1:0] ref_seq(input logic [7:0] l);
        logic [1:0] b;
        b = l[1:0];
        return (b == 2'b00) ? 2'b01 : b;
    endfunction

    function automatic logic [6:0] ref_seg(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic check_idle(input string tag, input logic [6:0] exp_tl);
        check_val({tag, "_seq"}, 32'(seq_o), 32'd0);
        check_val({tag, "_stop"}, 32'(stop_o), 32'd1);
        check_val({tag, "_tl"}, 32'(time_left_o), 32'(exp_tl));
    endtask

    // Starts a round at this negedge and checks every cycle up to the end-of-round edge.
    task automatic run_round(input bit hold, input int pulse_at);
        logic [1:0] exp_seq, pend;
        int exp_tl;
        start   = 1'b1;
        exp_seq = ref_seq(m_lfsr);
        pend    = 2'b00;
        @(negedge clk_i);
        if (!hold) start = 1'b0;
        check_val("start_stop", 32'(stop_o), 32'd0);
        check_val("start_seq", 32'(seq_o), 32'(exp_seq));
        check_val("start_tl", 32'(time_left_o), 32'd3);
        check_val("start_disp_g", 32'(disp_g_t_o), 32'(ref_seg(3)));
        for (int k = 1; k <= RoundClks; k++) begin
            if (k % SlotClks == 0) pend = ref_seq(m_lfsr);
            if (k == pulse_at) start = 1'b1;
            if (k == pulse_at + 1) start = 1'b0;
            @(negedge clk_i);
            if (k == RoundClks)              exp_seq = 2'b00;
            else if (k % SlotClks == 0)      exp_seq = pend;
            else if (k % SlotClks == GapStart) exp_seq = 2'b00;
            exp_tl = (k >= RoundClks) ? 0 : 3 - k / SecClks;
            check_val("seq", 32'(seq_o), 32'(exp_seq));
            check_val("stop", 32'(stop_o), (k >= RoundClks) ? 32'd1 : 32'd0);
            check_val("time_left", 32'(time_left_o), 32'(exp_tl));
            if (k % SecClks == 0) begin
                check_val("disp_g", 32'(disp_g_t_o), 32'(ref_seg(exp_tl)));
                check_val("disp_s", 32'(disp_s_t_o), 32'(ref_seg(0)));
            end
            if (seq_o == 2'b11) seen11 = 1'b1;
        end
        if (hold) begin
            // Start still high in DONE must not retrigger.
            repeat (20) begin
                @(negedge clk_i);
                check_idle("hold_done", 7'd0);
            end
            start = 1'b0;
            @(negedge clk_i);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        repeat (3) @(negedge clk_i);
        check_idle("reset", 7'd3);
        clr = 1'b1;
        repeat (20) begin
            @(negedge clk_i);
            check_idle("idle", 7'd3);
        end
        check_val("idle_disp_g", 32'(disp_g_t_o), 32'(7'b0110000));
        check_val("idle_disp_s", 32'(disp_s_t_o), 32'(7'b1000000));

        run_round(1'b0, -1);
        repeat (10) begin
            @(negedge clk_i);
            check_idle("done", 7'd0);
        end
        check_val("done_disp_g", 32'(disp_g_t_o), 32'(7'b1000000));

        // Restart from DONE with a stray start pulse mid-round
        run_round(1'b0, 150);

        // Find a mid-slot seq=10 and clear asynchronously
        found = 1'b0;
        for (int r = 0; r < 6 && !found; r++) begin
            start = 1'b1;
            @(negedge clk_i);
            start = 1'b0;
            for (int k = 1; k < 295 && !found; k++) begin
                if (seq_o == 2'b10 && stop_o == 1'b0) found = 1'b1;
                else @(negedge clk_i);
            end
            if (!found) repeat (20) @(negedge clk_i);
        end
        check_val("clr_found_10", 32'(found), 32'd1);
        #2 clr = 1'b0;
        #1;
        check_idle("clr_async", 7'd3);
        check_val("clr_disp_g", 32'(disp_g_t_o), 32'(7'b0110000));
        repeat (3) @(negedge clk_i);
        check_idle("clr_held", 7'd3);
        clr   = 1'b1;
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
        // Seed 8'hA5 has low bits 01
        check_val("clr_seed_seq", 32'(seq_o), 32'd1);
        check_val("clr_seed_stop", 32'(stop_o), 32'd0);
        clr = 1'b0;
        @(negedge clk_i);
        clr = 1'b1;
        @(negedge clk_i);
        check_idle("reclr", 7'd3);

        // About 200 slots with start held high through each round
        seen11 = 1'b0;
        for (int r = 0; r < 27; r++) run_round(1'b1, -1);
        check_val("seen_11", 32'(seen11), 32'd1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
